// File: rtl/axi_dma_fsm.sv
// Descriptor-driven DMA sequencer: walks the enabled descriptors, splits each into
// 4 KB-safe AXI bursts, and issues paired read/write burst requests to the streamers.
module axi_dma_fsm #(
   parameter int unsigned DMA_NUM_DESC       = 2,
   parameter int unsigned DMA_ADDR_WIDTH     = 32,
   parameter int unsigned DMA_DATA_WIDTH     = 32,
   parameter int unsigned DMA_MAX_BEAT_BURST = 256
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     dma_go_i,
   input  logic                                     dma_abort_i,
   input  logic [DMA_NUM_DESC*DMA_ADDR_WIDTH-1:0]   desc_src_addr_i,
   input  logic [DMA_NUM_DESC*DMA_ADDR_WIDTH-1:0]   desc_dst_addr_i,
   input  logic [DMA_NUM_DESC*DMA_ADDR_WIDTH-1:0]   desc_num_bytes_i,
   input  logic [DMA_NUM_DESC-1:0]                  desc_en_i,
   output logic                                     rd_req_valid_o,
   input  logic                                     rd_req_ready_i,
   output logic [DMA_ADDR_WIDTH-1:0]                rd_req_addr_o,
   output logic [7:0]                               rd_req_len_o,
   output logic                                     wr_req_valid_o,
   input  logic                                     wr_req_ready_i,
   output logic [DMA_ADDR_WIDTH-1:0]                wr_req_addr_o,
   output logic [7:0]                               wr_req_len_o,
   input  logic                                     rd_txn_done_i,
   input  logic                                     wr_txn_done_i,
   input  logic                                     err_i,
   input  logic                                     err_src_i,
   input  logic [DMA_ADDR_WIDTH-1:0]                err_addr_i,
   output logic                                     dma_active_o,
   output logic                                     dma_done_o,
   output logic                                     dma_error_o,
   output logic [DMA_ADDR_WIDTH-1:0]                error_addr_o,
   output logic                                     error_type_o,
   output logic                                     error_src_o
);
   localparam int unsigned AW         = DMA_ADDR_WIDTH;
   localparam int unsigned BPB        = DMA_DATA_WIDTH / 8;
   localparam int unsigned BEAT_SHIFT = $clog2(BPB);
   localparam int unsigned PTR_W      = $clog2(DMA_NUM_DESC + 1);
   localparam logic [AW-1:0] ALIGN_MASK = AW'(BPB - 1);
   localparam logic [AW-1:0] MAX_BYTES  = AW'(DMA_MAX_BEAT_BURST * BPB);
   localparam logic [AW-1:0] PAGE_BYTES = AW'(4096);
   localparam logic [AW-1:0] PAGE_MASK  = AW'(4095);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_WAIT, S_DRAIN, S_FINISH} state_t;

   state_t           state;
   logic [PTR_W-1:0] ptr, sel_idx;
   logic             sel_found, cfg_bad;
   logic [AW-1:0]    sel_src, sel_dst, sel_num;
   logic [AW-1:0]    src, dst, rem, cur_bytes;
   logic [AW-1:0]    b_src, b_dst, b_rem, b_bytes, src_room, dst_room;
   logic [7:0]       b_len;
   logic             rd_out, wr_out, err_flag;
   logic             rd_hs, wr_hs, rd_pend_nx, wr_pend_nx, rd_out_nx, wr_out_nx;
   logic             busy, any_acc;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_src   = '0;
      sel_dst   = '0;
      sel_num   = '0;
      for (int unsigned i = 0; i < DMA_NUM_DESC; i++) begin
         if (!sel_found && i >= 32'(ptr) && desc_en_i[i] &&
             desc_num_bytes_i[i*AW +: AW] != '0) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(i);
            sel_src   = desc_src_addr_i[i*AW +: AW];
            sel_dst   = desc_dst_addr_i[i*AW +: AW];
            sel_num   = desc_num_bytes_i[i*AW +: AW];
         end
      end
      cfg_bad = ((sel_src | sel_dst | sel_num) & ALIGN_MASK) != '0;
   end

   // Next burst is sized from the freshly selected slot in SETUP, otherwise from the
   // post-completion addresses so WAIT can issue the following burst directly.
   always_comb begin
      b_src    = (state == S_SETUP) ? sel_src : src + cur_bytes;
      b_dst    = (state == S_SETUP) ? sel_dst : dst + cur_bytes;
      b_rem    = (state == S_SETUP) ? sel_num : rem - cur_bytes;
      src_room = PAGE_BYTES - (b_src & PAGE_MASK);
      dst_room = PAGE_BYTES - (b_dst & PAGE_MASK);
      b_bytes  = b_rem;
      if (MAX_BYTES < b_bytes) b_bytes = MAX_BYTES;
      if (src_room < b_bytes)  b_bytes = src_room;
      if (dst_room < b_bytes)  b_bytes = dst_room;
      b_len = 8'((b_bytes >> BEAT_SHIFT) - AW'(1));
   end

   always_comb begin
      rd_hs      = rd_req_valid_o & rd_req_ready_i;
      wr_hs      = wr_req_valid_o & wr_req_ready_i;
      rd_pend_nx = rd_req_valid_o & ~rd_req_ready_i;
      wr_pend_nx = wr_req_valid_o & ~wr_req_ready_i;
      rd_out_nx  = (rd_out & ~rd_txn_done_i) | rd_hs;
      wr_out_nx  = (wr_out & ~wr_txn_done_i) | wr_hs;
      any_acc    = ~rd_pend_nx | ~wr_pend_nx;
      busy       = (state != S_IDLE) && (state != S_FINISH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         ptr            <= '0;
         src            <= '0;
         dst            <= '0;
         rem            <= '0;
         cur_bytes      <= '0;
         rd_out         <= 1'b0;
         wr_out         <= 1'b0;
         err_flag       <= 1'b0;
         rd_req_valid_o <= 1'b0;
         rd_req_addr_o  <= '0;
         rd_req_len_o   <= '0;
         wr_req_valid_o <= 1'b0;
         wr_req_addr_o  <= '0;
         wr_req_len_o   <= '0;
         dma_active_o   <= 1'b0;
         dma_done_o     <= 1'b0;
         dma_error_o    <= 1'b0;
         error_addr_o   <= '0;
         error_type_o   <= 1'b0;
         error_src_o    <= 1'b0;
      end else begin
         rd_out <= rd_out_nx;
         wr_out <= wr_out_nx;
         if (rd_hs) rd_req_valid_o <= 1'b0;
         if (wr_hs) wr_req_valid_o <= 1'b0;
         if (busy && err_i && !err_flag) begin
            err_flag     <= 1'b1;
            error_addr_o <= err_addr_i;
            error_src_o  <= err_src_i;
            error_type_o <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (dma_go_i) begin
                  state        <= S_SETUP;
                  ptr          <= '0;
                  err_flag     <= 1'b0;
                  dma_active_o <= 1'b1;
                  dma_done_o   <= 1'b0;
                  dma_error_o  <= 1'b0;
                  error_addr_o <= '0;
                  error_type_o <= 1'b0;
                  error_src_o  <= 1'b0;
               end
            end
            S_SETUP: begin
               if (err_i) begin
                  state <= S_DRAIN;
               end else if (dma_abort_i || !sel_found) begin
                  state <= S_FINISH;
               end else if (cfg_bad) begin
                  err_flag     <= 1'b1;
                  error_addr_o <= sel_src;
                  error_src_o  <= 1'b0;
                  error_type_o <= 1'b1;
                  state        <= S_FINISH;
               end else begin
                  ptr            <= sel_idx;
                  src            <= sel_src;
                  dst            <= sel_dst;
                  rem            <= sel_num;
                  cur_bytes      <= b_bytes;
                  rd_req_valid_o <= 1'b1;
                  rd_req_addr_o  <= b_src;
                  rd_req_len_o   <= b_len;
                  wr_req_valid_o <= 1'b1;
                  wr_req_addr_o  <= b_dst;
                  wr_req_len_o   <= b_len;
                  state          <= S_REQ;
               end
            end
            S_REQ: begin
               if (err_i) begin
                  state <= S_DRAIN;
               end else if (dma_abort_i) begin
                  if (any_acc) begin
                     state <= S_DRAIN;
                  end else begin
                     rd_req_valid_o <= 1'b0;
                     wr_req_valid_o <= 1'b0;
                     state          <= S_FINISH;
                  end
               end else if (!rd_pend_nx && !wr_pend_nx) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (err_i || dma_abort_i) begin
                  state <= S_DRAIN;
               end else if (!rd_out_nx && !wr_out_nx) begin
                  src <= b_src;
                  dst <= b_dst;
                  rem <= b_rem;
                  if (b_rem == '0) begin
                     ptr   <= ptr + 1'b1;
                     state <= S_SETUP;
                  end else begin
                     cur_bytes      <= b_bytes;
                     rd_req_valid_o <= 1'b1;
                     rd_req_addr_o  <= b_src;
                     rd_req_len_o   <= b_len;
                     wr_req_valid_o <= 1'b1;
                     wr_req_addr_o  <= b_dst;
                     wr_req_len_o   <= b_len;
                     state          <= S_REQ;
                  end
               end
            end
            S_DRAIN: begin
               if (!rd_pend_nx && !wr_pend_nx && !rd_out_nx && !wr_out_nx) state <= S_FINISH;
            end
            S_FINISH: begin
               dma_done_o   <= 1'b1;
               dma_error_o  <= err_flag;
               dma_active_o <= 1'b0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_dma_fsm.sv
// Self-checking bench for axi_dma_fsm: table of descriptor setups with expected bursts
// scoreboarded against a responder, plus hand-written abort/error/reset sequences.
`timescale 1ns/1ps
module tb_axi_dma_fsm;
   localparam int AW = 32;
   localparam int ND = 2;

   typedef struct packed {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [7:0]    len;
   } burst_t;

   typedef struct packed {
      logic [ND*AW-1:0] src;
      logic [ND*AW-1:0] dst;
      logic [ND*AW-1:0] num;
      logic [ND-1:0]    en;
      logic [2:0]       nb;
      burst_t [3:0]     b;
      logic             err;
      logic             etype;
      logic [AW-1:0]    eaddr;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic dma_go_i = 1'b0, dma_abort_i = 1'b0;
   logic [ND*AW-1:0] desc_src_addr_i = '0, desc_dst_addr_i = '0, desc_num_bytes_i = '0;
   logic [ND-1:0] desc_en_i = '0;
   logic rd_req_valid_o, rd_req_ready_i = 1'b0, wr_req_valid_o, wr_req_ready_i = 1'b0;
   logic [AW-1:0] rd_req_addr_o, wr_req_addr_o;
   logic [7:0] rd_req_len_o, wr_req_len_o;
   logic rd_txn_done_i = 1'b0, wr_txn_done_i = 1'b0;
   logic err_i = 1'b0, err_src_i = 1'b0;
   logic [AW-1:0] err_addr_i = '0;
   logic dma_active_o, dma_done_o, dma_error_o, error_type_o, error_src_o;
   logic [AW-1:0] error_addr_o;

   int unsigned n_checks = 0, n_pass = 0;
   burst_t rd_q[$], wr_q[$];
   burst_t rd_exp, wr_exp;
   vec_t vq[$];
   vec_t cur;
   logic rd_stall = 1'b0, wr_stall = 1'b0;
   int rd_cd = 0, wr_cd = 0, done_dly = 3;
   logic rd_hold = 1'b0, wr_hold = 1'b0;
   logic [AW-1:0] rd_cap_addr, wr_cap_addr;
   logic [7:0] rd_cap_len, wr_cap_len;

   always #5 clk = ~clk;

   axi_dma_fsm #(
      .DMA_NUM_DESC(ND), .DMA_ADDR_WIDTH(AW), .DMA_DATA_WIDTH(32), .DMA_MAX_BEAT_BURST(256)
   ) dut (
      .clk(clk), .rst(rst), .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i),
      .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
      .desc_num_bytes_i(desc_num_bytes_i), .desc_en_i(desc_en_i),
      .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i),
      .rd_req_addr_o(rd_req_addr_o), .rd_req_len_o(rd_req_len_o),
      .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
      .wr_req_addr_o(wr_req_addr_o), .wr_req_len_o(wr_req_len_o),
      .rd_txn_done_i(rd_txn_done_i), .wr_txn_done_i(wr_txn_done_i),
      .err_i(err_i), .err_src_i(err_src_i), .err_addr_i(err_addr_i),
      .dma_active_o(dma_active_o), .dma_done_o(dma_done_o), .dma_error_o(dma_error_o),
      .error_addr_o(error_addr_o), .error_type_o(error_type_o), .error_src_o(error_src_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Read-side responder: ready asserted at a negedge means the handshake lands on the next posedge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         rd_req_ready_i = 1'b0; rd_txn_done_i = 1'b0; rd_cd = 0; rd_hold = 1'b0;
      end else begin
         rd_txn_done_i = 1'b0;
         if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) rd_txn_done_i = 1'b1;
         end
         if (rd_req_ready_i) begin
            rd_req_ready_i = 1'b0; rd_hold = 1'b0;
            check("rd_burst_expected", 64'(rd_q.size() != 0), 64'd1);
            if (rd_q.size() != 0) begin
               rd_exp = rd_q.pop_front();
               check("rd_addr", 64'(rd_cap_addr), 64'(rd_exp.src));
               check("rd_len", 64'(rd_cap_len), 64'(rd_exp.len));
            end
            rd_cd = done_dly;
         end else if (rd_req_valid_o) begin
            if (rd_hold) check("rd_req_stable", {rd_req_addr_o, rd_req_len_o}, {rd_cap_addr, rd_cap_len});
            rd_cap_addr = rd_req_addr_o; rd_cap_len = rd_req_len_o; rd_hold = 1'b1;
            if (!rd_stall && $urandom_range(0, 2) != 0) rd_req_ready_i = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         wr_req_ready_i = 1'b0; wr_txn_done_i = 1'b0; wr_cd = 0; wr_hold = 1'b0;
      end else begin
         wr_txn_done_i = 1'b0;
         if (wr_cd > 0) begin
            wr_cd--;
            if (wr_cd == 0) wr_txn_done_i = 1'b1;
         end
         if (wr_req_ready_i) begin
            wr_req_ready_i = 1'b0; wr_hold = 1'b0;
            check("wr_burst_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
               wr_exp = wr_q.pop_front();
               check("wr_addr", 64'(wr_cap_addr), 64'(wr_exp.dst));
               check("wr_len", 64'(wr_cap_len), 64'(wr_exp.len));
            end
            wr_cd = done_dly;
         end else if (wr_req_valid_o) begin
            if (wr_hold) check("wr_req_stable", {wr_req_addr_o, wr_req_len_o}, {wr_cap_addr, wr_cap_len});
            wr_cap_addr = wr_req_addr_o; wr_cap_len = wr_req_len_o; wr_hold = 1'b1;
            if (!wr_stall && $urandom_range(0, 2) != 0) wr_req_ready_i = 1'b1;
         end
      end
   end

   task automatic new_vec(input logic [AW-1:0] s0, d0, n0, s1, d1, n1, input logic [1:0] en,
                          input logic e, et, input logic [AW-1:0] ea);
      cur = '0;
      cur.src = {s1, s0}; cur.dst = {d1, d0}; cur.num = {n1, n0}; cur.en = en;
      cur.err = e; cur.etype = et; cur.eaddr = ea;
   endtask

   task automatic add_burst(input logic [AW-1:0] s, d, input logic [7:0] len);
      cur.b[cur.nb] = '{src: s, dst: d, len: len};
      cur.nb = cur.nb + 3'd1;
   endtask

   task automatic load_vec(input vec_t v);
      desc_src_addr_i = v.src; desc_dst_addr_i = v.dst;
      desc_num_bytes_i = v.num; desc_en_i = v.en;
      for (int k = 0; k < int'(v.nb); k++) begin
         rd_q.push_back(v.b[k]);
         wr_q.push_back(v.b[k]);
      end
   endtask

   task automatic pulse_go();
      @(negedge clk); dma_go_i = 1'b1;
      @(negedge clk); dma_go_i = 1'b0;
   endtask

   task automatic wait_q_empty(input string name);
      int unsigned cyc = 0;
      while ((rd_q.size() != 0 || wr_q.size() != 0) && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      check(name, 64'(rd_q.size() + wr_q.size()), 64'd0);
   endtask

   task automatic finish_checks(input string tag, input logic e, et, es, input logic [AW-1:0] ea);
      int unsigned cyc = 0;
      while (!dma_done_o && cyc < 3000) begin
         @(negedge clk); cyc++;
      end
      check({tag, "_done"}, 64'(dma_done_o), 64'd1);
      check({tag, "_error"}, 64'(dma_error_o), 64'(e));
      check({tag, "_error_type"}, 64'(error_type_o), 64'(et));
      check({tag, "_error_src"}, 64'(error_src_o), 64'(es));
      check({tag, "_error_addr"}, 64'(error_addr_o), 64'(ea));
      check({tag, "_active"}, 64'(dma_active_o), 64'd0);
      check({tag, "_pending_dones"}, 64'(rd_cd + wr_cd), 64'd0);
      check({tag, "_bursts_missing"}, 64'(rd_q.size() + wr_q.size()), 64'd0);
      rd_q.delete(); wr_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // src/dst/bytes for slot0 then slot1, enables, expected err/type/addr
      new_vec(32'h1000, 32'h2000, 32'h40, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0);
      add_burst(32'h1000, 32'h2000, 8'd15); vq.push_back(cur);
      new_vec(32'h0FF0, 32'h3000, 32'h20, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0);
      add_burst(32'h0FF0, 32'h3000, 8'd3); add_burst(32'h1000, 32'h3010, 8'd3); vq.push_back(cur);
      new_vec(32'h0, 32'h8000, 32'h800, 32'h9000, 32'hA000, 32'h40, 2'b01, 1'b0, 1'b0, 32'h0);
      add_burst(32'h0, 32'h8000, 8'd255); add_burst(32'h400, 32'h8400, 8'd255); vq.push_back(cur);
      new_vec(32'h1002, 32'h2000, 32'h40, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 32'h1002);
      vq.push_back(cur);
      new_vec(32'h100, 32'h200, 32'h8, 32'h5000, 32'h6FF8, 32'h10, 2'b11, 1'b0, 1'b0, 32'h0);
      add_burst(32'h100, 32'h200, 8'd1); add_burst(32'h5000, 32'h6FF8, 8'd1);
      add_burst(32'h5008, 32'h7000, 8'd1); vq.push_back(cur);
      new_vec(32'h40, 32'h80, 32'h0, 32'h10, 32'h20, 32'h4, 2'b11, 1'b0, 1'b0, 32'h0);
      add_burst(32'h10, 32'h20, 8'd0); vq.push_back(cur);
      new_vec(32'h2000, 32'h3000, 32'h404, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0);
      add_burst(32'h2000, 32'h3000, 8'd255); add_burst(32'h2400, 32'h3400, 8'd0); vq.push_back(cur);
      new_vec(32'h1000, 32'h2000, 32'h40, 32'h1000, 32'h2000, 32'h40, 2'b00, 1'b0, 1'b0, 32'h0);
      vq.push_back(cur);
      new_vec(32'hFFFF_FFF0, 32'h10, 32'h20, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 32'h0);
      add_burst(32'hFFFF_FFF0, 32'h10, 8'd3); add_burst(32'h0, 32'h20, 8'd3); vq.push_back(cur);

      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rd_valid", 64'(rd_req_valid_o), 64'd0);
      check("rst_wr_valid", 64'(wr_req_valid_o), 64'd0);
      check("rst_status", {dma_active_o, dma_done_o, dma_error_o, error_type_o, error_src_o}, 64'd0);
      check("rst_error_addr", 64'(error_addr_o), 64'd0);
      #2 rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         load_vec(vq[i]);
         pulse_go();
         finish_checks($sformatf("vec%0d", i), vq[i].err, vq[i].etype, 1'b0, vq[i].eaddr);
      end

      // First request two cycles after go; a second go while busy changes nothing.
      load_vec(vq[1]);
      @(negedge clk); dma_go_i = 1'b1;
      @(negedge clk); dma_go_i = 1'b0;
      check("lat_setup_no_valid", 64'(rd_req_valid_o | wr_req_valid_o), 64'd0);
      @(negedge clk);
      check("lat_valids_n2", 64'({rd_req_valid_o, wr_req_valid_o}), 64'd3);
      pulse_go();
      finish_checks("go_busy", 1'b0, 1'b0, 1'b0, 32'h0);

      // Bus error while the first of two bursts is outstanding.
      done_dly = 20;
      cur = vq[2]; cur.nb = 3'd1;
      load_vec(cur);
      pulse_go();
      wait_q_empty("err_first_accepted");
      repeat (2) @(negedge clk);
      err_i = 1'b1; err_src_i = 1'b1; err_addr_i = 32'h2040;
      @(negedge clk); err_i = 1'b0; err_src_i = 1'b0; err_addr_i = '0;
      finish_checks("bus_err", 1'b1, 1'b0, 1'b1, 32'h2040);
      done_dly = 3;

      // Abort with the read accepted and the write stalled.
      wr_stall = 1'b1;
      load_vec(vq[0]);
      pulse_go();
      begin
         int unsigned cyc = 0;
         while (rd_q.size() != 0 && cyc < 500) begin
            @(negedge clk); cyc++;
         end
      end
      check("abort_rd_accepted", 64'(rd_q.size()), 64'd0);
      dma_abort_i = 1'b1;
      @(negedge clk); dma_abort_i = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_wr_held", 64'(wr_req_valid_o), 64'd1);
      check("abort_wr_addr", 64'(wr_req_addr_o), 64'h2000);
      check("abort_not_done", 64'(dma_done_o), 64'd0);
      wr_stall = 1'b0;
      finish_checks("abort", 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset while requests are pending drops the valids at once.
      rd_stall = 1'b1; wr_stall = 1'b1;
      load_vec(vq[0]);
      pulse_go();
      repeat (3) @(negedge clk);
      check("pre_rst_valid", 64'({rd_req_valid_o, wr_req_valid_o}), 64'd3);
      #2 rst = 1'b0;
      #1;
      check("async_rst_valid", 64'({rd_req_valid_o, wr_req_valid_o}), 64'd0);
      check("async_rst_active", 64'(dma_active_o), 64'd0);
      rd_q.delete(); wr_q.delete();
      rd_stall = 1'b0; wr_stall = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      load_vec(vq[4]);
      pulse_go();
      finish_checks("post_rst", 1'b0, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/axi_dma_fsm.md
AXI_DMA_FSM -- requirements
Module: axi_dma_fsm

Interface
REQ-001 Parameter DMA_NUM_DESC, 2, number of descriptor slots.
REQ-002 Parameter DMA_ADDR_WIDTH, 32, address width.
REQ-003 Parameter DMA_DATA_WIDTH, 32, AXI data width; BPB = DMA_DATA_WIDTH/8 bytes per beat.
REQ-004 Parameter DMA_MAX_BEAT_BURST, 256, max beats per burst (1..256).
REQ-005 Ports SHALL be exactly:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- dma_go_i  in  1  start pulse from CSR.
- dma_abort_i  in  1  abort pulse from CSR.
- desc_src_addr_i  in  DMA_NUM_DESC x DMA_ADDR_WIDTH  per-descriptor source address.
- desc_dst_addr_i  in  DMA_NUM_DESC x DMA_ADDR_WIDTH  per-descriptor destination address.
- desc_num_bytes_i  in  DMA_NUM_DESC x DMA_ADDR_WIDTH  per-descriptor byte count.
- desc_en_i  in  DMA_NUM_DESC  per-descriptor enable.
- rd_req_valid_o / rd_req_ready_i  out/in  1  read-burst request handshake.
- rd_req_addr_o  out  DMA_ADDR_WIDTH; rd_req_len_o  out  8  (AXI arlen encoding).
- wr_req_valid_o / wr_req_ready_i  out/in  1  write-burst request handshake.
- wr_req_addr_o  out  DMA_ADDR_WIDTH; wr_req_len_o  out  8  (AXI awlen encoding).
- rd_txn_done_i, wr_txn_done_i  in  1  one-cycle pulse per completed burst.
- err_i  in  1  streamer error pulse; err_src_i  in  1  (0 read, 1 write); err_addr_i  in  DMA_ADDR_WIDTH.
- dma_active_o  out  1  transfer in progress.
- dma_done_o, dma_error_o  out  1  level status to CSR/IRQ.
- error_addr_o  out  DMA_ADDR_WIDTH; error_type_o  out  1  (0 bus, 1 config); error_src_o  out  1.

Function
REQ-006 States: IDLE, SETUP, REQ, WAIT, DRAIN, FINISH.
REQ-007 IDLE: dma_go_i -> SETUP; clears dma_done_o, dma_error_o, error_* registers.
REQ-008 SETUP: select lowest-index descriptor >= current pointer with desc_en_i=1 and num_bytes != 0; none left -> FINISH; loads src, dst, remaining bytes from that slot.
REQ-009 SETUP config check: src, dst or num_bytes not multiple of BPB -> error_type_o=1, error_src_o=0, error_addr_o=src, go FINISH with error.
REQ-010 Burst bytes = min(remaining, DMA_MAX_BEAT_BURST*BPB, 4096-src[11:0], 4096-dst[11:0]); len = bytes/BPB-1; no burst crosses a 4 KB boundary.
REQ-011 REQ: rd_req_valid_o and wr_req_valid_o assert same cycle; each drops independently after its handshake; both accepted -> WAIT.
REQ-012 valid held, addr/len stable until ready; never withdrawn except by reset.
REQ-013 WAIT: count rd and wr done pulses (one outstanding burst per direction); both seen -> src+=bytes, dst+=bytes, remaining-=bytes; remaining=0 -> pointer++ and SETUP, else REQ.
REQ-014 Latency: go at cycle N -> first request valid at N+2.
REQ-015 Done pulses arriving in the same cycle SHALL both be counted; a done pulse with no outstanding burst is ignored.
REQ-016 dma_abort_i in SETUP/REQ -> FINISH if no burst accepted, else DRAIN; in WAIT -> DRAIN; in IDLE/FINISH ignored.
REQ-017 err_i in any busy state: capture err_addr_i, err_src_i, error_type_o=0 (first error only), go DRAIN.
REQ-018 DRAIN: issue no new requests; wait for done pulses of all accepted bursts; then FINISH.
REQ-019 FINISH: dma_done_o=1 (always, including abort/error); dma_error_o=1 if any error captured; -> IDLE next cycle; both held until next go.
REQ-020 dma_go_i outside IDLE SHALL be ignored; dma_active_o=1 in all states except IDLE.
REQ-021 Address arithmetic wraps modulo 2^DMA_ADDR_WIDTH.

Reset
REQ-022 rst low asynchronously forces IDLE, all outputs 0, descriptor pointer 0, counters 0.
REQ-023 Reset mid-transfer drops request valids immediately; outstanding bursts are forgotten.

Verification
REQ-024 Desc0 src=0x1000 dst=0x2000 bytes=0x40, en=1; go -> one rd/wr burst len=15, done=1, error=0.
REQ-025 Desc0 src=0x0FF0 dst=0x3000 bytes=0x20 -> bursts len=3 @0x0FF0/0x3000 then len=3 @0x1000/0x3010.
REQ-026 Desc0 bytes=0x800, desc1 en=0, desc2... (NUM_DESC=2) -> bursts of 1024 B (len=255) x2, desc1 skipped.
REQ-027 Desc0 src=0x1002 -> no requests, done=1, error=1, error_type=1, error_addr=0x1002.
REQ-028 err_i src=1 addr=0x2040 during WAIT of first of 2 bursts -> second burst not issued, error_addr=0x2040, done=1, error=1.
REQ-029 Abort during REQ with rd accepted, wr stalled -> wr held until ready, DRAIN waits both dones, done=1, error=0.
